// File: rtl/reg_exec_stage.sv
// Two-operand execute/writeback stage in front of a register file. A single S1 slot
// handles 1-cycle ALU ops and an iterative shift-add MUL. The WB slot drives the write port.
module reg_exec_stage #(
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned NumRegs    = 16,
    parameter int unsigned IndexWidth = $clog2(NumRegs),
    parameter int unsigned CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instValid,
    output logic                  instReady,
    input  logic [2:0]            instOp,
    input  logic [IndexWidth-1:0] instRd,
    input  logic [IndexWidth-1:0] instRs1,
    input  logic [IndexWidth-1:0] instRs2,
    input  logic [DataWidth-1:0]  instImm,
    output logic [IndexWidth-1:0] readAddr1,
    output logic [IndexWidth-1:0] readAddr2,
    input  logic [DataWidth-1:0]  readData1,
    input  logic [DataWidth-1:0]  readData2,
    output logic                  writeEn,
    output logic [IndexWidth-1:0] writeAddr,
    output logic [DataWidth-1:0]  writeData,
    output logic                  busy,
    output logic [CountWidth-1:0] retiredCount
);

    localparam int unsigned ShW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam logic [ShW-1:0] CntLast = ShW'(DataWidth - 1);

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpSll = 3'd5;
    localparam logic [2:0] OpLi  = 3'd6;
    localparam logic [2:0] OpMul = 3'd7;

    typedef enum logic [0:0] {StIdle, StMbusy} state_e;

    state_e                state_q, state_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [2:0]            s1_op_q, s1_op_d;
    logic [IndexWidth-1:0] s1_rd_q, s1_rd_d;
    logic [DataWidth-1:0]  s1_a_q, s1_a_d;
    logic [DataWidth-1:0]  s1_b_q, s1_b_d;
    logic [DataWidth-1:0]  acc_q, acc_d;
    logic [ShW-1:0]        cnt_q, cnt_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [IndexWidth-1:0] wb_rd_q, wb_rd_d;
    logic [DataWidth-1:0]  wb_data_q, wb_data_d;
    logic [CountWidth-1:0] retired_q;

    logic                  s1_done;
    logic                  accept;
    logic                  fwd1, fwd2;
    logic [DataWidth-1:0]  s1_result;
    logic [DataWidth-1:0]  op1, op2;

    assign readAddr1 = instRs1;
    assign readAddr2 = instRs2;

    // For MUL, s1_a_q/s1_b_q hold the shifting multiplicand/multiplier.
    always_comb begin
        s1_result = '0;
        case (s1_op_q)
            OpAdd:   s1_result = s1_a_q + s1_b_q;
            OpSub:   s1_result = s1_a_q - s1_b_q;
            OpAnd:   s1_result = s1_a_q & s1_b_q;
            OpOr:    s1_result = s1_a_q | s1_b_q;
            OpXor:   s1_result = s1_a_q ^ s1_b_q;
            OpSll:   s1_result = s1_a_q << s1_b_q[ShW-1:0];
            OpLi:    s1_result = s1_a_q;
            default: s1_result = acc_q + (s1_b_q[0] ? s1_a_q : '0);
        endcase
    end

    assign s1_done   = s1_valid_q && (state_q == StIdle || cnt_q == CntLast);
    assign instReady = !rst && (!s1_valid_q || s1_done);
    assign accept    = instValid && instReady;

    assign fwd1 = s1_done && (s1_rd_q != '0) && (s1_rd_q == instRs1);
    assign fwd2 = s1_done && (s1_rd_q != '0) && (s1_rd_q == instRs2);

    always_comb begin
        op1 = readData1;
        op2 = readData2;
        if (instOp == OpLi) begin
            op1 = instImm;
            op2 = '0;
        end else begin
            if (instRs1 == '0)  op1 = '0;
            else if (fwd1)      op1 = s1_result;
            if (instRs2 == '0)  op2 = '0;
            else if (fwd2)      op2 = s1_result;
        end
    end

    always_comb begin
        state_d    = state_q;
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_rd_d    = s1_rd_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;

        if (state_q == StMbusy && !s1_done) begin
            acc_d  = acc_q + (s1_b_q[0] ? s1_a_q : '0);
            s1_a_d = s1_a_q << 1;
            s1_b_d = s1_b_q >> 1;
            cnt_d  = cnt_q + 1'b1;
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = instOp;
            s1_rd_d    = instRd;
            s1_a_d     = op1;
            s1_b_d     = op2;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = (instOp == OpMul) ? StMbusy : StIdle;
        end else if (s1_done) begin
            s1_valid_d = 1'b0;
            state_d    = StIdle;
        end
    end

    // WB never stalls: it simply captures whatever S1 completes this cycle.
    always_comb begin
        wb_valid_d = s1_done;
        wb_rd_d    = s1_done ? s1_rd_q : wb_rd_q;
        wb_data_d  = s1_done ? s1_result : wb_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_rd_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_rd_q    <= s1_rd_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            retired_q  <= retired_q + CountWidth'(writeEn);
        end
    end

    // Writes to r0 are suppressed so the register file bypass never sees them.
    assign writeEn      = wb_valid_q && (wb_rd_q != '0);
    assign writeAddr    = wb_rd_q;
    assign writeData    = wb_data_q;
    assign busy         = s1_valid_q || wb_valid_q;
    assign retiredCount = retired_q;

endmodule

// File: tb/tb_reg_exec_stage.sv
// Bench for reg_exec_stage: models the register file (with write bypass), runs directed
// vector tables plus a random program checked against an in-order architectural model.
module tb_reg_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instValid = 1'b0;
    logic        instReady;
    logic [2:0]  instOp = '0;
    logic [3:0]  instRd = '0, instRs1 = '0, instRs2 = '0;
    logic [7:0]  instImm = '0;
    logic [3:0]  readAddr1, readAddr2;
    logic [7:0]  readData1, readData2;
    logic        writeEn;
    logic [3:0]  writeAddr;
    logic [7:0]  writeData;
    logic        busy;
    logic [15:0] retiredCount;

    reg_exec_stage dut (
        .clk(clk), .rst(rst),
        .instValid(instValid), .instReady(instReady), .instOp(instOp),
        .instRd(instRd), .instRs1(instRs1), .instRs2(instRs2), .instImm(instImm),
        .readAddr1(readAddr1), .readAddr2(readAddr2),
        .readData1(readData1), .readData2(readData2),
        .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
        .busy(busy), .retiredCount(retiredCount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model with same-cycle write bypass.
    logic [7:0] rf [16];
    always @(posedge clk) if (writeEn) rf[writeAddr] <= writeData;
    always_comb begin
        readData1 = rf[readAddr1];
        readData2 = rf[readAddr2];
        if (writeEn && writeAddr == readAddr1) readData1 = writeData;
        if (writeEn && writeAddr == readAddr2) readData2 = writeData;
        if (readAddr1 == 4'd0) readData1 = 8'd0;
        if (readAddr2 == 4'd0) readData2 = 8'd0;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural model: instructions take effect in program order at accept time.
    typedef struct { logic [3:0] rd; logic [7:0] data; int cyc; } exp_t;
    exp_t       expq[$];
    logic [7:0] arch [16];
    int         exp_retired = 0;
    bit         table_mode = 1'b1;
    bit         cur_we = 1'b0;
    logic [7:0] cur_data = '0;

    function automatic logic [7:0] ref_calc(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] imm);
        int unsigned ia = a, ib = b, r;
        case (op)
            3'd0: r = ia + ib;
            3'd1: r = ia - ib;
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: r = ia << (ib % 8);
            3'd6: r = imm;
            default: r = ia * ib;
        endcase
        return 8'(r);
    endfunction

    always @(negedge clk) begin
        if (writeEn) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got r%0d=%0h with no write expected (cycle %0d)",
                         writeAddr, writeData, cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                n_cmp++;
                if (writeAddr !== e.rd || writeData !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL writeback: got r%0d=%0h at cycle %0d expected r%0d=%0h at cycle %0d",
                             writeAddr, writeData, cyc, e.rd, e.data, e.cyc);
                end
            end
        end
        if (instValid && instReady) begin
            int lat;
            logic [7:0] a, b, v;
            lat = (instOp == 3'd7) ? 9 : 2;
            a = (instRs1 == 4'd0) ? 8'd0 : arch[instRs1];
            b = (instRs2 == 4'd0) ? 8'd0 : arch[instRs2];
            v = ref_calc(instOp, a, b, instImm);
            if (table_mode) begin
                if (cur_we) begin
                    expq.push_back('{rd: instRd, data: cur_data, cyc: cyc + lat});
                    arch[instRd] = cur_data;
                    exp_retired++;
                end
            end else if (instRd != 4'd0) begin
                expq.push_back('{rd: instRd, data: v, cyc: cyc + lat});
                arch[instRd] = v;
                exp_retired++;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [7:0] imm, input bit we,
                        input logic [7:0] data, output int waited);
        bit got;
        @(posedge clk);
        #1;
        cur_we = we;
        cur_data = data;
        instValid = 1'b1;
        instOp = op;
        instRd = rd;
        instRs1 = rs1;
        instRs2 = rs2;
        instImm = imm;
        waited = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (instReady) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept within 40 cycles");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            instValid = 1'b0;
            instOp = 3'($urandom);
            instRd = 4'($urandom);
            instRs1 = 4'($urandom);
            instRs2 = 4'($urandom);
            instImm = 8'($urandom);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && expq.size() != 0; k++) idle(1);
        idle(3);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        chk("retired_count", 32'(retiredCount), 32'(exp_retired));
    endtask

    typedef struct {
        logic [2:0] op; logic [3:0] rd, rs1, rs2; logic [7:0] imm;
        bit we; logic [7:0] data; int wait_cyc;
    } vec_t;
    vec_t tbl[13];

    initial begin
        int w;
        tbl[0]  = '{3'd6, 4'd1,  4'd0,  4'd0,  8'h05, 1'b1, 8'h05, 0};
        tbl[1]  = '{3'd6, 4'd2,  4'd0,  4'd0,  8'h03, 1'b1, 8'h03, 0};
        tbl[2]  = '{3'd0, 4'd3,  4'd1,  4'd2,  8'h00, 1'b1, 8'h08, 0};
        tbl[3]  = '{3'd1, 4'd4,  4'd2,  4'd1,  8'h00, 1'b1, 8'hFE, 0};
        tbl[4]  = '{3'd5, 4'd5,  4'd1,  4'd2,  8'h00, 1'b1, 8'h28, 0};
        tbl[5]  = '{3'd4, 4'd6,  4'd1,  4'd1,  8'h00, 1'b1, 8'h00, 0};
        tbl[6]  = '{3'd7, 4'd7,  4'd1,  4'd2,  8'h00, 1'b1, 8'h0F, 0};
        tbl[7]  = '{3'd0, 4'd8,  4'd7,  4'd1,  8'h00, 1'b1, 8'h14, 7};
        tbl[8]  = '{3'd6, 4'd11, 4'd0,  4'd0,  8'h10, 1'b1, 8'h10, 0};
        tbl[9]  = '{3'd6, 4'd12, 4'd0,  4'd0,  8'h20, 1'b1, 8'h20, 0};
        tbl[10] = '{3'd7, 4'd13, 4'd11, 4'd12, 8'h00, 1'b1, 8'h00, 0};
        tbl[11] = '{3'd6, 4'd0,  4'd0,  4'd0,  8'h55, 1'b0, 8'h00, 7};
        tbl[12] = '{3'd0, 4'd9,  4'd0,  4'd1,  8'h00, 1'b1, 8'h05, 0};
        for (int i = 0; i < 16; i++) begin
            rf[i] = 8'd0;
            arch[i] = 8'd0;
        end

        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_writeEn", 32'(writeEn), 32'd0);
        chk("rst_writeAddr", 32'(writeAddr), 32'd0);
        chk("rst_writeData", 32'(writeData), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_instReady", 32'(instReady), 32'd0);
        chk("rst_retired", 32'(retiredCount), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(instReady), 32'd1);

        // Directed vectors: back-to-back issue, forwarding, MUL stall and truncation, r0.
        for (int i = 0; i < 13; i++) begin
            send(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm,
                 tbl[i].we, tbl[i].data, w);
            chk($sformatf("stall_cycles[%0d]", i), 32'(w), 32'(tbl[i].wait_cyc));
        end
        idle(1);
        chk("busy_in_flight", 32'(busy), 32'd1);
        drain();
        chk("busy_idle", 32'(busy), 32'd0);

        // Reset in cycle 4 of a MUL: aborted, no writeback.
        send(3'd7, 4'd10, 4'd1, 4'd2, 8'h00, 1'b0, 8'h00, w);
        idle(3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_retired = 0;
        @(negedge clk);
        chk("mul_rst_writeEn", 32'(writeEn), 32'd0);
        chk("mul_rst_busy", 32'(busy), 32'd0);
        chk("mul_rst_ready", 32'(instReady), 32'd0);
        chk("mul_rst_retired", 32'(retiredCount), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mul_rst_ready_after", 32'(instReady), 32'd1);
        chk("mul_rst_busy_after", 32'(busy), 32'd0);
        idle(12);
        chk("r10_untouched", 32'(rf[10]), 32'd0);
        chk("retired_after_abort", 32'(retiredCount), 32'd0);

        // Random dependent program with random issue gaps.
        table_mode = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [2:0] op;
            op = (i % 5 == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            send(op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 7)), 8'($urandom), 1'b0, 8'h00, w);
            idle($urandom_range(0, 2));
        end
        idle(1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
